uart_bus_slave: RTL

Memory-mapped UART responder on the CPU data bus, decoded alongside data memory in the MEM stage. It answers CPU loads and stores to three UART registers and serialises/deserialises 8N1 frames on `uart_tx`/`uart_rx`. It raises a level interrupt toward the CPU on transmit-done and receive-full.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_core.sv | 78 +++++++
 rtl/uart_bus_slave.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register addresses, CON bit positions and FSM state encoding
package uart_pkg;
  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;
  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_FULL   = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_RX_OVR    = 5;
  localparam int CON_FRAME_ERR = 6;
  localparam int CON_TX_OVF    = 7;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronises the serial input and recovers 8N1 bytes
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OSR_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  localparam int DW = $clog2(OSR_DIV + 1);
  logic [1:0]    sync_q;
  logic [DW-1:0] div_q;
  logic          tick;
  logic          rx_s;
  uart_state_t   state_q;
  logic [3:0]    tcnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  assign rx_s = sync_q[1];
  assign tick = div_q == DW'(OSR_DIV - 1);
  // two-flop synchroniser, idles high like the line
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], rx_i};
  // free-running oversample divider
  always_ff @(posedge clk or posedge rst)
    if (rst) div_q <= '0;
    else div_q <= tick ? '0 : div_q + 1'b1;
  // receive FSM: mid-start check, 16-tick bit spacing, stop-bit verdict
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      byte_valid_o <= 1'b0;
      byte_o       <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          tcnt_q  <= '0;
        end
        START: if (tick) begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == 4'd7) begin
            tcnt_q  <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end
        end
        DATA: if (tick) begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == 4'd15) begin
            sh_q  <= {rx_s, sh_q[7:1]};
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        end
        default: if (tick) begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == 4'd15) begin
            byte_valid_o <= rx_s;
            frame_err_o  <= !rx_s;
            byte_o       <= sh_q;
            state_q      <= IDLE;
          end
        end
      endcase
    end
endmodule

// File: rtl/uart_bus_slave.sv
// uart_bus_slave: memory-mapped 8N1 UART with TXD/RXD/CON registers and level irq
module uart_bus_slave
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int OSR_DIV  = (CLK_FREQ / (BAUD * 16)) < 1 ? 1 : CLK_FREQ / (BAUD * 16)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int BIT = 16 * OSR_DIV;
  localparam int CW  = $clog2(BIT);
  uart_state_t tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic [7:0]    txd_q;
  logic          tx_q;
  logic [7:0]    rx_data_q;
  logic          tx_irq_en_q, rx_irq_en_q, tx_done_q, rx_full_q;
  logic          rx_ovr_q, frame_err_q, tx_ovf_q, irq_q;
  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_byte;
  logic          sel_txd, sel_rxd, sel_con;
  logic          tx_busy, tx_accept, tx_bit_end, tx_end;
  logic          txd_wr, rxd_rd, con_rd, con_wr;
  logic [7:0]    con;
  logic          unused_wdata;
  assign unused_wdata = ^wdata[31:8];
  assign sel_txd    = addr == UART_TXD_ADDR;
  assign sel_rxd    = addr == UART_RXD_ADDR;
  assign sel_con    = addr == UART_CON_ADDR;
  assign txd_wr     = wr & sel_txd;
  assign rxd_rd     = rd & sel_rxd;
  assign con_rd     = rd & sel_con;
  assign con_wr     = wr & sel_con;
  assign tx_busy    = tx_state_q != IDLE;
  assign tx_accept  = txd_wr & !tx_busy;
  assign tx_bit_end = tx_cnt_q == CW'(BIT - 1);
  assign tx_end     = tx_state_q == STOP && tx_bit_end;
  assign con = {tx_ovf_q, frame_err_q, rx_ovr_q, tx_busy, rx_full_q, tx_done_q, rx_irq_en_q, tx_irq_en_q};
  assign rdata = !rd    ? 32'h0 :
                 sel_txd ? {24'h0, txd_q} :
                 sel_rxd ? {24'h0, rx_data_q} :
                 sel_con ? {24'h0, con} : 32'h0;
  assign uart_tx = tx_q;
  assign irq     = irq_q;
  uart_rx_core #(.OSR_DIV(OSR_DIV)) u_rx (
    .clk          (clk),
    .rst          (reset),
    .rx_i         (uart_rx),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (rx_ferr)
  );
  // transmit FSM: each state lasts BIT cycles, data goes out LSB first
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= '0;
      tx_q       <= 1'b1;
    end else if (tx_accept) begin
      tx_state_q <= START;
      tx_cnt_q   <= '0;
      tx_sh_q    <= wdata[7:0];
      txd_q      <= wdata[7:0];
      tx_q       <= 1'b0;
    end else if (tx_busy) begin
      tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      if (tx_bit_end)
        case (tx_state_q)
          START: begin
            tx_state_q <= DATA;
            tx_bit_q   <= '0;
            tx_q       <= tx_sh_q[0];
          end
          DATA: begin
            tx_bit_q   <= tx_bit_q + 1'b1;
            tx_sh_q    <= tx_sh_q >> 1;
            tx_q       <= tx_bit_q == 3'd7 ? 1'b1 : tx_sh_q[1];
            tx_state_q <= tx_bit_q == 3'd7 ? STOP : DATA;
          end
          default: begin
            tx_state_q <= IDLE;
            tx_q       <= 1'b1;
          end
        endcase
    end
  // CON/RXD state: new events take priority over read-to-clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_full_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_data_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      if (con_wr) {rx_irq_en_q, tx_irq_en_q} <= wdata[1:0];
      tx_done_q   <= tx_end | (tx_done_q & !con_rd);
      tx_ovf_q    <= (txd_wr & tx_busy) | (tx_ovf_q & !con_rd);
      rx_ovr_q    <= (rx_valid & rx_full_q & !rxd_rd) | (rx_ovr_q & !con_rd);
      frame_err_q <= rx_ferr | (frame_err_q & !con_rd);
      rx_full_q   <= rx_valid | (rx_full_q & !rxd_rd);
      if (rx_valid & (!rx_full_q | rxd_rd)) rx_data_q <= rx_byte;
      irq_q       <= (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_full_q);
    end
endmodule
